// File: rtl/mcu_mailbox_reader.sv
// mcu_mailbox_reader
// Wishbone-side master that drains MCU-to-FPGA mailbox messages from a shared
// dual-port BRAM. The BRAM port has no ack and a fixed 1-cycle read latency,
// so every bus cycle is exactly one clock long and timed by this block.
// The header {seq, len} is polled until seq differs from the last acknowledged
// one. The payload is then streamed on valid/ready, and {seq, len_clamped} is
// written back to the acknowledge word.
module mcu_mailbox_reader #(
   parameter logic [9:0]  BASE_ADDR = 10'h000,
   parameter logic [9:0]  HDR_ADDR  = 10'h3FE,
   parameter logic [9:0]  ACK_ADDR  = 10'h3FF,
   parameter logic [7:0]  MAX_LEN   = 8'd255,
   parameter int unsigned POLL_DIV  = 16
) (
   input  logic        clk_i,
   input  logic        resetn,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [9:0]  wb_adr_o,
   output logic [1:0]  wb_sel_o,
   output logic [15:0] wb_dat_o,
   input  logic [15:0] wb_dat_i,
   input  logic        enable_i,
   output logic [15:0] m_data_o,
   output logic        m_valid_o,
   input  logic        m_ready_i,
   output logic        m_last_o,
   output logic        busy_o,
   output logic [7:0]  msg_count_o
);

   localparam int unsigned      CNT_W    = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(POLL_DIV - 1);

   typedef enum logic [2:0] {
      ST_WAIT    = 3'd0,
      ST_HDR_RD  = 3'd1,
      ST_HDR_CHK = 3'd2,
      ST_DAT_RD  = 3'd3,
      ST_DAT_OUT = 3'd4,
      ST_ACK_WR  = 3'd5
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [7:0]       last_seq_q;
   logic [7:0]       seq_q;
   logic [7:0]       len_q;
   logic [7:0]       idx_q;
   logic             wb_cyc_q;
   logic             wb_we_q;
   logic [9:0]       wb_adr_q;
   logic [1:0]       wb_sel_q;
   logic [15:0]      wb_dat_q;
   logic [15:0]      m_data_q;
   logic             m_valid_q;
   logic             m_last_q;
   logic             busy_q;
   logic [7:0]       msg_count_q;

   logic [7:0]       hdr_len_d;
   logic [7:0]       idx_next_d;
   logic [9:0]       dat_adr_d;
   logic             last_hit_d;

   // Header length clamp, next payload index/address, and last-word detect.
   always_comb begin
      hdr_len_d  = wb_dat_i[7:0];
      if (wb_dat_i[7:0] > MAX_LEN) begin
         hdr_len_d = MAX_LEN;
      end else begin
         hdr_len_d = wb_dat_i[7:0];
      end
      idx_next_d = idx_q + 8'd1;
      dat_adr_d  = BASE_ADDR + {2'b00, idx_next_d};
      last_hit_d = (idx_q == (len_q - 8'd1));
   end

   // Mailbox FSM; all bus and stream outputs are registered here.
   always_ff @(posedge clk_i) begin
      if (!resetn) begin
         state_q     <= ST_WAIT;
         cnt_q       <= '0;
         last_seq_q  <= 8'h00;
         seq_q       <= 8'h00;
         len_q       <= 8'h00;
         idx_q       <= 8'h00;
         wb_cyc_q    <= 1'b0;
         wb_we_q     <= 1'b0;
         wb_adr_q    <= 10'h000;
         wb_sel_q    <= 2'b00;
         wb_dat_q    <= 16'h0000;
         m_data_q    <= 16'h0000;
         m_valid_q   <= 1'b0;
         m_last_q    <= 1'b0;
         busy_q      <= 1'b0;
         msg_count_q <= 8'h00;
      end else begin
         case (state_q)
            ST_WAIT: begin
               if (cnt_q == CNT_TERM) begin
                  // Terminal count is held until polling is allowed.
                  if (enable_i) begin
                     state_q  <= ST_HDR_RD;
                     wb_cyc_q <= 1'b1;
                     wb_we_q  <= 1'b0;
                     wb_sel_q <= 2'b00;
                     wb_adr_q <= HDR_ADDR;
                  end else begin
                     cnt_q <= cnt_q;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_HDR_RD: begin
               // Single-cycle read; data returns during HDR_CHK.
               state_q  <= ST_HDR_CHK;
               wb_cyc_q <= 1'b0;
               wb_adr_q <= 10'h000;
            end
            ST_HDR_CHK: begin
               if (wb_dat_i[15:8] == last_seq_q) begin
                  state_q <= ST_WAIT;
                  cnt_q   <= '0;
               end else begin
                  seq_q  <= wb_dat_i[15:8];
                  len_q  <= hdr_len_d;
                  idx_q  <= 8'h00;
                  busy_q <= 1'b1;
                  if (hdr_len_d == 8'd0) begin
                     state_q  <= ST_ACK_WR;
                     wb_cyc_q <= 1'b1;
                     wb_we_q  <= 1'b1;
                     wb_sel_q <= 2'b11;
                     wb_adr_q <= ACK_ADDR;
                     wb_dat_q <= {wb_dat_i[15:8], 8'd0};
                  end else begin
                     state_q  <= ST_DAT_RD;
                     wb_cyc_q <= 1'b1;
                     wb_we_q  <= 1'b0;
                     wb_sel_q <= 2'b00;
                     wb_adr_q <= BASE_ADDR;
                  end
               end
            end
            ST_DAT_RD: begin
               state_q  <= ST_DAT_OUT;
               wb_cyc_q <= 1'b0;
               wb_adr_q <= 10'h000;
            end
            ST_DAT_OUT: begin
               if (!m_valid_q) begin
                  // First DAT_OUT cycle: read data is on wb_dat_i now.
                  m_data_q  <= wb_dat_i;
                  m_valid_q <= 1'b1;
                  m_last_q  <= last_hit_d;
               end else if (m_ready_i) begin
                  m_valid_q <= 1'b0;
                  m_last_q  <= 1'b0;
                  idx_q     <= idx_next_d;
                  if (m_last_q) begin
                     state_q  <= ST_ACK_WR;
                     wb_cyc_q <= 1'b1;
                     wb_we_q  <= 1'b1;
                     wb_sel_q <= 2'b11;
                     wb_adr_q <= ACK_ADDR;
                     wb_dat_q <= {seq_q, len_q};
                  end else begin
                     state_q  <= ST_DAT_RD;
                     wb_cyc_q <= 1'b1;
                     wb_we_q  <= 1'b0;
                     wb_sel_q <= 2'b00;
                     wb_adr_q <= dat_adr_d;
                  end
               end else begin
                  // Sink stalled: hold the presented word.
                  m_valid_q <= 1'b1;
               end
            end
            ST_ACK_WR: begin
               state_q     <= ST_WAIT;
               cnt_q       <= '0;
               wb_cyc_q    <= 1'b0;
               wb_we_q     <= 1'b0;
               wb_sel_q    <= 2'b00;
               wb_adr_q    <= 10'h000;
               wb_dat_q    <= 16'h0000;
               last_seq_q  <= seq_q;
               msg_count_q <= msg_count_q + 8'd1;
               busy_q      <= 1'b0;
            end
            default: begin
               state_q   <= ST_WAIT;
               cnt_q     <= '0;
               wb_cyc_q  <= 1'b0;
               wb_we_q   <= 1'b0;
               wb_sel_q  <= 2'b00;
               wb_adr_q  <= 10'h000;
               m_valid_q <= 1'b0;
               m_last_q  <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign wb_cyc_o    = wb_cyc_q;
   assign wb_stb_o    = wb_cyc_q;
   assign wb_we_o     = wb_we_q;
   assign wb_adr_o    = wb_adr_q;
   assign wb_sel_o    = wb_sel_q;
   assign wb_dat_o    = wb_dat_q;
   assign m_data_o    = m_data_q;
   assign m_valid_o   = m_valid_q;
   assign m_last_o    = m_last_q;
   assign busy_o      = busy_q;
   assign msg_count_o = msg_count_q;

endmodule

// File: tb/tb_mcu_mailbox_reader.sv
// tb_mcu_mailbox_reader
// Self-checking bench: BRAM model with 1-cycle read latency, bus/stream
// loggers, and a message-level reference model (expected words, addresses
// and ack computed from the mailbox rules with plain arithmetic).
module tb_mcu_mailbox_reader;

   localparam logic [9:0] P_BASE = 10'h3FC;
   localparam logic [9:0] P_HDR  = 10'h100;
   localparam logic [9:0] P_ACK  = 10'h101;
   localparam logic [7:0] P_MAX  = 8'd6;
   localparam int         P_POLL = 5;
   localparam int         BUDGET = 3000;

   logic        clk_i;
   logic        resetn;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [9:0]  wb_adr_o;
   logic [1:0]  wb_sel_o;
   logic [15:0] wb_dat_o;
   logic [15:0] wb_dat_i;
   logic        enable_i;
   logic [15:0] m_data_o;
   logic        m_valid_o;
   logic        m_ready_i;
   logic        m_last_o;
   logic        busy_o;
   logic [7:0]  msg_count_o;

   mcu_mailbox_reader #(
      .BASE_ADDR(P_BASE), .HDR_ADDR(P_HDR), .ACK_ADDR(P_ACK),
      .MAX_LEN(P_MAX), .POLL_DIV(P_POLL)
   ) dut (
      .clk_i(clk_i), .resetn(resetn),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
      .wb_dat_i(wb_dat_i), .enable_i(enable_i),
      .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
      .m_last_o(m_last_o), .busy_o(busy_o), .msg_count_o(msg_count_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // BRAM model: registered read data, DUT write port and a host (MCU) port.
   logic [15:0] mem [1024];
   logic        host_we;
   logic [9:0]  host_adr;
   logic [15:0] host_dat;
   int          cycle_no;

   always @(posedge clk_i) begin
      wb_dat_i <= mem[wb_adr_o];
      if (wb_cyc_o && wb_we_o) mem[wb_adr_o] <= wb_dat_o;
      if (host_we) mem[host_adr] <= host_dat;
      cycle_no <= cycle_no + 1;
   end

   typedef struct packed {
      logic        we;
      logic [9:0]  adr;
      logic [15:0] dat;
      logic [1:0]  sel;
      logic [31:0] cyc;
   } bus_t;

   bus_t        bus_log [$];
   logic [16:0] strm_log [$];
   int          proto_err;
   int          checks;
   int          errors;

   logic [15:0] model_mem [1024];
   logic [7:0]  model_last;
   logic [7:0]  model_cnt;

   // Logger: bus cycles, stream handshakes, stb/sel rules and stall stability.
   initial begin
      bus_t        e;
      logic        prev_stall;
      logic [15:0] prev_data;
      logic        prev_last;
      prev_stall = 1'b0;
      prev_data  = 16'h0000;
      prev_last  = 1'b0;
      forever begin
         @(negedge clk_i);
         if (wb_stb_o !== wb_cyc_o) proto_err++;
         if (wb_cyc_o === 1'b1) begin
            if (wb_sel_o !== (wb_we_o ? 2'b11 : 2'b00)) proto_err++;
            e.we  = wb_we_o;
            e.adr = wb_adr_o;
            e.dat = wb_dat_o;
            e.sel = wb_sel_o;
            e.cyc = 32'(cycle_no);
            bus_log.push_back(e);
         end
         if (m_valid_o === 1'b1 && m_ready_i === 1'b1) strm_log.push_back({m_last_o, m_data_o});
         if (prev_stall && resetn &&
             (m_valid_o !== 1'b1 || m_data_o !== prev_data || m_last_o !== prev_last)) proto_err++;
         prev_stall = m_valid_o && !m_ready_i && resetn;
         prev_data  = m_data_o;
         prev_last  = m_last_o;
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic mcu_write(input logic [9:0] adr, input logic [15:0] dat);
      host_we  = 1'b1;
      host_adr = adr;
      host_dat = dat;
      tick();
      host_we = 1'b0;
      model_mem[adr] = dat;
   endtask

   task automatic fill_payload(input int n);
      for (int i = 0; i < n; i++) mcu_write(P_BASE + 10'(i), 16'($urandom));
   endtask

   // Publish a header and check the whole resulting message against the model.
   // mode: 0 ready high, 1 random ready, 2 five-cycle stall on word index 1.
   task automatic run_msg(input logic [7:0] seq, input logic [7:0] len, input int mode, input bit drop_en);
      int          n;
      int          budget;
      int          stall_left;
      int          busy_bad;
      int          bad;
      int          base;
      logic [9:0]  a;
      logic [15:0] ack_exp;
      logic [15:0] exp_w [$];
      n = (len > P_MAX) ? int'(P_MAX) : int'(len);
      for (int i = 0; i < n; i++) begin
         a = P_BASE + 10'(i);
         exp_w.push_back(model_mem[a]);
      end
      ack_exp = {seq, 8'(n)};
      bus_log.delete();
      strm_log.delete();
      stall_left = 5;
      busy_bad   = 0;
      budget     = 0;
      mcu_write(P_HDR, {seq, len});
      while (msg_count_o === model_cnt && budget < BUDGET) begin
         if (drop_en && strm_log.size() > 0) enable_i = 1'b0;
         if (m_valid_o === 1'b1 && busy_o !== 1'b1) busy_bad++;
         case (mode)
            0: m_ready_i = 1'b1;
            1: m_ready_i = ($urandom_range(0, 3) != 0);
            default: begin
               if (m_valid_o === 1'b1 && strm_log.size() == 1 && stall_left > 0) begin
                  m_ready_i = 1'b0;
                  stall_left--;
                  chk("stall_data", 32'(m_data_o), 32'(exp_w[1]));
               end else begin
                  m_ready_i = 1'b1;
               end
            end
         endcase
         tick();
         budget++;
      end
      chk("msg_timeout", 32'(budget < BUDGET), 32'd1);
      chk("msg_count", 32'(msg_count_o), 32'(model_cnt + 8'd1));
      chk("busy_after", 32'(busy_o), 32'd0);
      chk("busy_during", 32'(busy_bad), 32'd0);
      chk("stream_len", 32'(strm_log.size()), 32'(n));
      bad = 0;
      for (int i = 0; i < n && i < strm_log.size(); i++)
         if (strm_log[i] !== {(i == n - 1), exp_w[i]}) bad++;
      chk("stream_data", 32'(bad), 32'd0);
      base = bus_log.size() - (n + 2);
      chk("bus_count", 32'(base >= 0), 32'd1);
      if (base >= 0) begin
         bad = 0;
         for (int i = 0; i <= base; i++)
            if (bus_log[i].we !== 1'b0 || bus_log[i].adr !== P_HDR) bad++;
         for (int i = 0; i < n; i++) begin
            a = P_BASE + 10'(i);
            if (bus_log[base + 1 + i].we !== 1'b0 || bus_log[base + 1 + i].adr !== a) bad++;
         end
         chk("bus_reads", 32'(bad), 32'd0);
         chk("ack_we", 32'(bus_log[base + n + 1].we), 32'd1);
         chk("ack_adr", 32'(bus_log[base + n + 1].adr), 32'(P_ACK));
         chk("ack_dat", 32'(bus_log[base + n + 1].dat), 32'(ack_exp));
      end
      model_mem[P_ACK] = ack_exp;
      model_last = seq;
      model_cnt  = model_cnt + 8'd1;
   endtask

   // Run idle cycles and check that nothing is consumed and polls are regular.
   task automatic no_msg(input int cycles);
      int bad;
      bus_log.delete();
      strm_log.delete();
      m_ready_i = 1'b1;
      repeat (cycles) tick();
      chk("idle_stream", 32'(strm_log.size()), 32'd0);
      chk("idle_count", 32'(msg_count_o), 32'(model_cnt));
      chk("idle_busy", 32'(busy_o), 32'd0);
      bad = 0;
      for (int i = 0; i < bus_log.size(); i++)
         if (bus_log[i].we !== 1'b0 || bus_log[i].adr !== P_HDR) bad++;
      for (int i = 1; i < bus_log.size(); i++)
         if (bus_log[i].cyc - bus_log[i - 1].cyc !== 32'(P_POLL + 2)) bad++;
      chk("idle_polls", 32'(bad), 32'd0);
      if (enable_i) chk("idle_poll_seen", 32'(bus_log.size() >= 2), 32'd1);
      else          chk("idle_no_poll", 32'(bus_log.size()), 32'd0);
   endtask

   initial begin
      logic [7:0] seq;
      logic [7:0] len;
      int         budget;
      int         writes;
      resetn     = 1'b0;
      enable_i   = 1'b0;
      m_ready_i  = 1'b1;
      host_we    = 1'b0;
      host_adr   = 10'h000;
      host_dat   = 16'h0000;
      model_last = 8'h00;
      model_cnt  = 8'h00;

      // Memory cleared while the DUT is held in reset.
      for (int i = 0; i < 1024; i++) mcu_write(10'(i), 16'h0000);
      chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
      chk("rst_stb", 32'(wb_stb_o), 32'd0);
      chk("rst_we", 32'(wb_we_o), 32'd0);
      chk("rst_adr", 32'(wb_adr_o), 32'd0);
      chk("rst_sel", 32'(wb_sel_o), 32'd0);
      chk("rst_dat", 32'(wb_dat_o), 32'd0);
      chk("rst_valid", 32'(m_valid_o), 32'd0);
      chk("rst_last", 32'(m_last_o), 32'd0);
      chk("rst_data", 32'(m_data_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_count", 32'(msg_count_o), 32'd0);
      resetn = 1'b1;
      tick();

      // seq 0 equals last_seq after reset: polled, never consumed.
      mcu_write(P_HDR, 16'h0003);
      enable_i = 1'b1;
      no_msg(50);

      // Basic three-word message.
      mcu_write(P_BASE, 16'h1111);
      mcu_write(P_BASE + 10'd1, 16'h2222);
      mcu_write(P_BASE + 10'd2, 16'h3333);
      run_msg(8'h01, 8'h03, 0, 1'b0);

      // Same payload with a stall on the second word.
      run_msg(8'h02, 8'h03, 2, 1'b0);

      // Zero length: ack only.
      run_msg(8'h04, 8'h00, 0, 1'b0);

      // Length above MAX_LEN is clamped, ack carries the clamped length.
      fill_payload(int'(P_MAX));
      run_msg(8'h05, 8'h09, 0, 1'b0);

      // Six words from 3FC wrap through 000/001.
      fill_payload(6);
      run_msg(8'h06, 8'h06, 1, 1'b0);

      // Header with the already-acknowledged seq is ignored.
      mcu_write(P_HDR, {model_last, 8'h05});
      no_msg(40);

      // Randomized messages.
      for (int r = 0; r < 10; r++) begin
         seq = 8'($urandom);
         while (seq == model_last) seq = 8'($urandom);
         if ($urandom_range(0, 3) == 0) len = 8'($urandom_range(7, 255));
         else                           len = 8'($urandom_range(0, 6));
         fill_payload((len > P_MAX) ? int'(P_MAX) : int'(len));
         run_msg(seq, len, 1, 1'b0);
      end

      // Enable dropped mid-message: message completes, then polling stops.
      seq = model_last + 8'd1;
      fill_payload(5);
      run_msg(seq, 8'd5, 0, 1'b1);
      no_msg(60);
      enable_i = 1'b1;

      // Reset while a word is presented: no ack, message restreamed once.
      fill_payload(4);
      seq = (model_last == 8'hA5) ? 8'h5A : 8'hA5;
      bus_log.delete();
      strm_log.delete();
      m_ready_i = 1'b0;
      mcu_write(P_HDR, {seq, 8'd4});
      budget = 0;
      while (m_valid_o !== 1'b1 && budget < BUDGET) begin
         tick();
         budget++;
      end
      chk("rst_reach_out", 32'(budget < BUDGET), 32'd1);
      resetn = 1'b0;
      tick();
      chk("mrst_cyc", 32'(wb_cyc_o), 32'd0);
      chk("mrst_we", 32'(wb_we_o), 32'd0);
      chk("mrst_adr", 32'(wb_adr_o), 32'd0);
      chk("mrst_valid", 32'(m_valid_o), 32'd0);
      chk("mrst_last", 32'(m_last_o), 32'd0);
      chk("mrst_data", 32'(m_data_o), 32'd0);
      chk("mrst_busy", 32'(busy_o), 32'd0);
      chk("mrst_count", 32'(msg_count_o), 32'd0);
      writes = 0;
      for (int i = 0; i < bus_log.size(); i++) if (bus_log[i].we === 1'b1) writes++;
      chk("mrst_no_ack", 32'(writes), 32'd0);
      resetn     = 1'b1;
      model_last = 8'h00;
      model_cnt  = 8'h00;
      run_msg(seq, 8'd4, 0, 1'b0);
      no_msg(60);

      chk("protocol", 32'(proto_err), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mcu_mailbox_reader.md
Name: mcu_mailbox_reader

Overview:
- Wishbone-side master that drains MCU-to-FPGA messages from the shared MCU dual-port BRAM (16-bit Wishbone port, 10-bit word address).
- Polls a header word that the MCU writes last. Streams the payload words out on a valid/ready interface, then writes an acknowledge word back so the MCU can reuse the buffer.
- Sits directly in front of the BRAM's Wishbone port. That port has no ack, so this block owns all bus timing.

Parameters:
- BASE_ADDR, 10'h000, word address of payload word 0
- HDR_ADDR, 10'h3FE, word address of header {seq[15:8], len[7:0]}
- ACK_ADDR, 10'h3FF, word address of acknowledge word
- MAX_LEN, 8'd255, payload length clamp in words (1..255)
- POLL_DIV, 16, idle cycles between header polls (>=1)

Ports:
- clk_i, in, 1, system clock
- resetn, in, 1, synchronous active-low reset
- wb_cyc_o, out, 1, bus cycle to BRAM port
- wb_stb_o, out, 1, strobe; always equal to wb_cyc_o
- wb_we_o, out, 1, write enable
- wb_adr_o, out, 10, word address
- wb_sel_o, out, 2, byte select; 2'b11 on writes, 2'b00 otherwise
- wb_dat_o, out, 16, write data
- wb_dat_i, in, 16, BRAM read data, valid the cycle after address
- enable_i, in, 1, allow starting new polls
- m_data_o, out, 16, payload word
- m_valid_o, out, 1, payload valid
- m_ready_i, in, 1, sink ready
- m_last_o, out, 1, final word of message (qualified by m_valid_o)
- busy_o, out, 1, high from header accept until ack written
- msg_count_o, out, 8, messages completed, wraps 255->0

Behaviour:
- Clock and reset:
  - Single clock domain: clk_i.
  - Reset is synchronous, active-low: resetn sampled on rising clk_i.
  - Outputs in reset: all wb_* = 0, m_valid_o = 0, m_last_o = 0, m_data_o = 0, busy_o = 0, msg_count_o = 0.
  - Internal state in reset: last_seq = 8'h00, state = WAIT, poll counter = 0.
- Bus rule: the BRAM gives no ack and has 1-cycle read latency.
  - A read is one cycle with cyc/stb high and we low; wb_dat_i is sampled on the following edge.
  - A write is one cycle with cyc/stb/we high.
  - cyc/stb are low in every other cycle.
- FSM states: WAIT, HDR_RD, HDR_CHK, DAT_RD, DAT_OUT, ACK_WR.
- WAIT:
  - Counts to POLL_DIV-1, then goes to HDR_RD if enable_i = 1.
  - If enable_i = 0, holds at terminal count.
- HDR_RD: wb_adr_o = HDR_ADDR, read cycle -> HDR_CHK.
- HDR_CHK: sample wb_dat_i.
  - If seq == last_seq: go to WAIT and clear the counter.
  - Else: latch seq; latch len = min(len, MAX_LEN); idx = 0; busy_o = 1.
  - Then: if len == 0 go to ACK_WR, else go to DAT_RD.
- DAT_RD: wb_adr_o = (BASE_ADDR + idx) mod 1024, read cycle -> DAT_OUT.
- DAT_OUT:
  - On entry: m_data_o = wb_dat_i, m_valid_o = 1, m_last_o = (idx == len-1).
  - m_data_o and m_last_o are held stable while m_valid_o = 1 and m_ready_i = 0.
  - On m_valid_o & m_ready_i: m_valid_o = 0 next cycle, idx += 1.
  - Then: last word -> ACK_WR, else -> DAT_RD.
- Throughput: at most one payload word per 2 cycles (3 including the handshake cycle when m_ready_i is held high).
- ACK_WR:
  - Write cycle: wb_adr_o = ACK_ADDR, wb_dat_o = {seq, len_clamped}, wb_sel_o = 2'b11.
  - Then: last_seq = seq, msg_count_o += 1, busy_o = 0 -> WAIT.
- Enable and header timing:
  - enable_i affects only the WAIT -> HDR_RD decision. A message in progress always completes, including its ack.
  - The header is sampled only in HDR_CHK. Header changes during a message are seen at the next poll.
  - A header whose seq equals the current last_seq is never consumed. This includes seq 0 right after reset.
- Boundaries:
  - BASE_ADDR + idx wraps at 10 bits.
  - len > MAX_LEN delivers exactly MAX_LEN words, and the ack carries the clamped length.
- Reset mid-message: immediately abandons the message with no ack written; all outputs return to reset values the next cycle.

Test Plan:
- Poll with unchanged header: reset; header = 16'h0003 -> wb reads at 3FE every POLL_DIV+2 cycles; no m_valid_o; no writes.
- Basic message:
  - Stimulus: BRAM[0..2] = 1111, 2222, 3333; header = 16'h0103; m_ready_i tied 1.
  - Required: words 1111, 2222, 3333 in order; m_last_o only on 3333.
  - Required: write of 16'h0103 to 3FF; msg_count_o = 1; busy_o low after ack.
- Backpressure: same message with m_ready_i low 5 cycles on word 2 -> m_data_o stays 2222 with m_valid_o high; no extra bus reads during the stall.
- Zero length and clamp:
  - Header 16'h0200 -> no stream; ack 16'h0200.
  - With MAX_LEN = 4, header 16'h0309 -> exactly 4 words; ack 16'h0304.
- Address wrap: BASE_ADDR = 10'h3FC, len 6 -> read addresses 3FC, 3FD, 3FE, 3FF, 000, 001 in order.
- Enable and reset:
  - Deassert enable_i mid-message -> message completes and acks; no further polls.
  - Assert resetn = 0 during DAT_OUT -> outputs cleared next cycle; no ack write; same seq re-read and restreamed once after a new poll (last_seq = 0).
